logic_result_fifo: RTL and testbench

LOGIC_RESULT_FIFO -- requirements
Module: logic_result_fifo

---
 rtl/logic_result_fifo.sv | 111 +++++++++++
 tb/tb_logic_result_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/logic_result_fifo.sv
// Circular-buffer FIFO for results of the bit-wise operator stage.
// One-cycle registered read, registered occupancy flags, sticky overflow/underflow.
module logic_result_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [WIDTH-1:0]         y_in,
  input  logic                     wr_en_in,
  input  logic                     rd_en_in,
  input  logic                     clr_flags_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     overflow_out,
  output logic                     underflow_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_ev;
  logic             w_udf_ev;
  logic [CW-1:0]    w_count_next;
  logic [AW-1:0]    w_wr_ptr_next;
  logic [AW-1:0]    w_rd_ptr_next;

  // A full FIFO can still take a write when the head is popped on the same edge.
  assign w_rd_acc = rd_en_in && !r_empty;
  assign w_wr_acc = wr_en_in && (!r_full || w_rd_acc);
  assign w_ovf_ev = wr_en_in && !w_wr_acc;
  assign w_udf_ev = rd_en_in && r_empty;

  assign w_wr_ptr_next = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_next = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Entry storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (w_wr_acc && !rst_in) begin
      r_mem[r_wr_ptr] <= y_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
      r_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_next;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= w_rd_ptr_next;
        r_data   <= r_mem[r_rd_ptr];
      end
      // A fresh event in the clearing cycle keeps its flag set.
      if (clr_flags_in) begin
        r_overflow  <= w_ovf_ev;
        r_underflow <= w_udf_ev;
      end else begin
        r_overflow  <= r_overflow  | w_ovf_ev;
        r_underflow <= r_underflow | w_udf_ev;
      end
    end
  end

  assign data_out      = r_data;
  assign valid_out     = r_valid;
  assign full_out      = r_full;
  assign empty_out     = r_empty;
  assign count_out     = r_count;
  assign overflow_out  = r_overflow;
  assign underflow_out = r_underflow;

endmodule

// File: tb/tb_logic_result_fifo.sv
// Scoreboard bench for logic_result_fifo: a queue-based reference model predicts
// every pop and the flag/occupancy state; a monitor checks each presented entry.
module tb_logic_result_fifo;
  localparam int W = 7;
  localparam int D = 4;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [W-1:0] y_in;
  logic         wr_en_in;
  logic         rd_en_in;
  logic         clr_flags_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         full_out;
  logic         empty_out;
  logic [$clog2(D):0] count_out;
  logic         overflow_out;
  logic         underflow_out;

  logic_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .y_in(y_in), .wr_en_in(wr_en_in),
    .rd_en_in(rd_en_in), .clr_flags_in(clr_flags_in), .data_out(data_out),
    .valid_out(valid_out), .full_out(full_out), .empty_out(empty_out),
    .count_out(count_out), .overflow_out(overflow_out), .underflow_out(underflow_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  bit           m_ovf = 0;
  bit           m_udf = 0;
  logic [W-1:0] last_data = '0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_state();
    chk("count", int'(count_out), mq.size());
    chk("full", int'(full_out), int'(mq.size() == D));
    chk("empty", int'(empty_out), int'(mq.size() == 0));
    chk("overflow", int'(overflow_out), int'(m_ovf));
    chk("underflow", int'(underflow_out), int'(m_udf));
  endtask

  task automatic check_reset_outputs();
    chk("rst_count", int'(count_out), 0);
    chk("rst_empty", int'(empty_out), 1);
    chk("rst_full", int'(full_out), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_ovf", int'(overflow_out), 0);
    chk("rst_udf", int'(underflow_out), 0);
  endtask

  // One clock of stimulus; the model predicts the state after the next rising edge.
  task automatic cycle(input bit wr, input bit rd, input bit clr, input logic [W-1:0] y);
    bit rd_ok, wr_ok, ov_ev, ud_ev;
    @(negedge clk_in);
    check_state();
    wr_en_in     = wr;
    rd_en_in     = rd;
    clr_flags_in = clr;
    y_in         = y;
    rd_ok = rd && (mq.size() > 0);
    wr_ok = wr && ((mq.size() < D) || rd_ok);
    ov_ev = wr && !wr_ok;
    ud_ev = rd && (mq.size() == 0);
    if (rd_ok) exp_q.push_back(mq.pop_front());
    if (wr_ok) mq.push_back(y);
    m_ovf = clr ? ov_ev : (m_ovf | ov_ev);
    m_udf = clr ? ud_ev : (m_udf | ud_ev);
  endtask

  task automatic drain();
    while (mq.size() > 0) cycle(0, 1, 0, '0);
  endtask

  // Reset asserted between edges; outputs must reach reset values before any edge.
  task automatic async_reset();
    cycle(0, 0, 0, '0);
    #2;
    chk("pre_reset_count", int'(count_out), mq.size());
    rst_in = 1'b1;
    #1;
    check_reset_outputs();
    mq.delete();
    exp_q.delete();
    m_ovf = 0;
    m_udf = 0;
    last_data = '0;
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk_in);
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("pop data=%02h expected=%02h", data_out, e);
          chk("pop_data", int'(data_out), int'(e));
          last_data = e;
        end
      end else begin
        chk("data_hold", int'(data_out), int'(last_data));
      end
    end
  end

  initial begin : driver
    rst_in = 1'b1; wr_en_in = 0; rd_en_in = 0; clr_flags_in = 0; y_in = '0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b0;

    // Fill, then drain in order.
    cycle(1, 0, 0, 7'h15); cycle(1, 0, 0, 7'h2A); cycle(1, 0, 0, 7'h7F); cycle(1, 0, 0, 7'h00);
    drain();

    // Write while full without read is dropped.
    cycle(1, 0, 0, 7'h01); cycle(1, 0, 0, 7'h02); cycle(1, 0, 0, 7'h03); cycle(1, 0, 0, 7'h04);
    cycle(1, 0, 0, 7'h11);
    drain();
    cycle(0, 0, 1, '0);

    // Full with simultaneous write and read.
    cycle(1, 0, 0, 7'h21); cycle(1, 0, 0, 7'h22); cycle(1, 0, 0, 7'h23); cycle(1, 0, 0, 7'h24);
    cycle(1, 1, 0, 7'h33);
    drain();

    // Empty with simultaneous write and read: no pass-through.
    cycle(1, 1, 0, 7'h44);
    cycle(0, 1, 0, '0);
    cycle(0, 0, 1, '0);

    // 1:1 streaming through ten entries.
    cycle(1, 0, 0, 7'h50);
    for (int i = 1; i < 10; i++) cycle(1, 1, 0, 7'(8'h50 + i));
    cycle(0, 1, 0, '0);

    // Mid-operation reset discards entries; next read underflows.
    cycle(1, 0, 0, 7'h61); cycle(1, 0, 0, 7'h62); cycle(1, 0, 0, 7'h63);
    async_reset();
    cycle(0, 1, 0, '0);

    // Clear concurrent with new events: set wins.
    cycle(1, 0, 0, 7'h71); cycle(1, 0, 0, 7'h72); cycle(1, 0, 0, 7'h73); cycle(1, 0, 0, 7'h74);
    cycle(1, 0, 1, 7'h75);
    drain();
    cycle(0, 1, 1, '0);
    cycle(0, 0, 1, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 6, 7'($urandom));
    end
    drain();
    cycle(0, 0, 0, '0);
    cycle(0, 0, 0, '0);
    @(negedge clk_in);
    #1;
    chk("leftover_expected", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
